fifo_rr_write_arbiter: RTL and testbench
========================================

# fifo_rr_write_arbiter

Round-robin write-side arbiter that shares one FIFO write port (`wr`/`din`/`full`) between `NUM_REQ` producers. It sits directly in front of the FIFO wrapper. A requester that wins arbitration keeps the port for a burst of up to `MAX_BURST` consecutive writes, which keeps short packets contiguous. The grant then rotates so that every requester gets a bounded wait.

## Interface

Parameters:
- `NUM_REQ`, 4: number of producers, ≥2.
- `DATA_WIDTH`, 32: FIFO word width.
- `MAX_BURST`, 4: maximum accepted writes per grant, ≥1.

Ports:
- `clk` input, 1: single clock; all state updates on rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `req_wr` input, `NUM_REQ`: bit i high means producer i presents a valid word.
- `req_din` input, `NUM_REQ*DATA_WIDTH`: producer i word at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ack` output, `NUM_REQ`: one-hot or zero; bit i high means producer i's word is written at this edge.
- `full` input, 1: FIFO full.
- `wr` output, 1: FIFO write strobe.
- `din` output, `DATA_WIDTH`: FIFO write data.
- `grant_valid` output, 1: registered; an owner currently holds the port.
- `grant_id` output, `$clog2(NUM_REQ)`: registered; current or last owner index.

## Operation

State:
- `state` ∈ {IDLE, BUSY}.
- `owner`: index of the current owner.
- `ptr`: round-robin start index.
- `burst_cnt`: width `$clog2(MAX_BURST+1)`.

IDLE:
- Candidate = first i scanning `ptr, ptr+1, …` modulo `NUM_REQ` with `req_wr[i]`=1.
- If a candidate exists and `full`=0:
  - Write the candidate this cycle: `wr`=1, `din`=candidate word, `req_ack[candidate]`=1.
  - `owner`←candidate, `burst_cnt`←1.
  - If `MAX_BURST`==1: stay in IDLE with `ptr`←candidate+1 (mod `NUM_REQ`).
  - Otherwise: go to BUSY.
- If there is no candidate, or `full`=1: no write, no state change. `ptr` is not advanced.

BUSY:
- If `req_wr[owner]`=1 and `full`=0:
  - Write the owner's word and ack it; `burst_cnt`++.
  - If the new `burst_cnt`==`MAX_BURST`: go to IDLE, `ptr`←owner+1.
- If `req_wr[owner]`=1 and `full`=1: hold. No write, count unchanged, grant kept.
- If `req_wr[owner]`=0: release. Go to IDLE, `ptr`←owner+1, no write this cycle (one dead cycle per handoff).
- Other requesters are ignored in BUSY.

Output rules:
- `wr` = OR of `req_ack`.
- `din` = selected word when `wr`=1; otherwise `din` = `req_din` slice of `grant_id`, which is don't-care for the FIFO.
- `wr` is never asserted while `full`=1.
- `grant_valid`=1 iff `state`==BUSY.
- `grant_id` = `owner`.
- Index arithmetic wraps modulo `NUM_REQ`. Non-power-of-2 `NUM_REQ` is supported via explicit wrap from `NUM_REQ-1` to 0.

Reset:
- `state`=IDLE, `ptr`=0, `owner`=0, `burst_cnt`=0.
- While `rst`=1, `wr` and `req_ack` are forced to 0 regardless of inputs.
- Reset mid-burst drops the grant immediately. No write occurs on the reset edge.

## Timing

- Request-to-write latency is zero cycles: `wr`, `din` and `req_ack` are combinational from `req_wr`, `req_din`, `full` and registered state.
- A producer must hold `req_wr` and its data stable until it sees `req_ack` at a rising edge. The word is consumed at that edge.
- Registered outputs (`grant_valid`, `grant_id`) update one edge after the decision.
- Sustained throughput is 1 word/cycle within a burst. A handoff costs 0 cycles when the burst ends by count and 1 cycle when it ends by release.
- Fairness bound: with `full`=0, a continuously requesting producer is acked within `(NUM_REQ-1)*(MAX_BURST+1)+1` cycles.
- `full` rising mid-burst stalls without losing the grant. Writes resume on the first cycle with `full`=0.

## Test plan

- Reset, then `req_wr`=4'b0001 held with data 0x5A, 0xF6, 0x09, 0xC4, 0x81, … → acks on 4 consecutive cycles, FIFO receives 0x5A, 0xF6, 0x09, 0xC4. `grant_valid` drops and producer 0 is re-granted from IDLE the next cycle. Output order matches input order.
- All four producers requesting continuously with `full`=0 → grants rotate 0,1,2,3,0…, 4 writes each. No producer waits more than 16 cycles.
- Owner 2 deasserts after 2 writes while producer 3 is requesting → exactly 1 dead cycle, then producer 3 is written. `ptr` is 3 when 3 wins.
- `full`=1 for 3 cycles in the middle of producer 1's burst → `wr`=0 for those cycles, `grant_id` stays 1, burst completes after `full` drops. Total 4 writes, none dropped or duplicated.
- `rst` pulsed while BUSY with owner 3 → `wr`=0 on the reset cycle. After reset, `grant_valid`=0 and `ptr`=0, so producer 0 wins over 3 when both request.
- Random `req_wr`/`full` run for 10k cycles with per-producer scoreboard → FIFO contents equal each producer's stream in order, `wr`&`full` never both 1, and `req_ack` is always one-hot or zero.

Source files
------------

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO write port between
// NUM_REQ producers. A winner keeps the port for up to MAX_BURST accepted
// writes, then the grant rotates to the next index after the owner.
module fifo_rr_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
  output logic [NUM_REQ-1:0]            req_ack,
  input  logic                          full,
  output logic                          wr,
  output logic [DATA_WIDTH-1:0]         din,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] owner, owner_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;

  logic             cand_found;
  logic [IDX_W-1:0] cand_idx;
  logic [IDX_W-1:0] sel_idx;

  // Increment an index with an explicit wrap so non-power-of-2 NUM_REQ works.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  // First requesting producer scanning ptr, ptr+1, ... modulo NUM_REQ.
  always_comb begin
    int j;
    cand_found = 1'b0;
    cand_idx   = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!cand_found && req_wr[IDX_W'(j)]) begin
        cand_found = 1'b1;
        cand_idx   = IDX_W'(j);
      end
    end
  end

  // State register; all arbitration state clears on synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      ptr       <= ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Next-state decision and zero-latency write acknowledge.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_nxt     = state;
    owner_nxt     = owner;
    ptr_nxt       = ptr;
    burst_cnt_nxt = burst_cnt;
    req_ack       = '0;
    sel_idx       = owner;

    case (state)
      IDLE: begin
        if (cand_found && !full) begin
          req_ack[cand_idx] = 1'b1;
          sel_idx           = cand_idx;
          owner_nxt         = cand_idx;
          burst_cnt_nxt     = CNT_W'(1);
          if (MAX_BURST == 1) ptr_nxt = wrap_inc(cand_idx);
          else                state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (req_wr[owner]) begin
          // Full stalls the burst but keeps the grant.
          if (!full) begin
            req_ack[owner] = 1'b1;
            burst_cnt_nxt  = burst_cnt + 1'b1;
            if (burst_cnt_nxt == BURST_MAX) begin
              state_nxt = IDLE;
              ptr_nxt   = wrap_inc(owner);
            end
          end
        end else begin
          // Owner dropped its request: release, costing one dead cycle.
          state_nxt = IDLE;
          ptr_nxt   = wrap_inc(owner);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // No word is consumed on a reset edge.
    if (rst) begin
      req_ack = '0;
      sel_idx = owner;
    end
  end

  assign wr          = |req_ack;
  assign din         = req_din[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign grant_valid = (state == BUSY);
  assign grant_id    = owner;

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Self-checking bench for fifo_rr_write_arbiter: a directed vector table,
// hand-written multi-cycle sequences and a scoreboarded random run.
module tb_fifo_rr_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_wr;
  logic [N*DW-1:0] req_din;
  logic [N-1:0]    req_ack;
  logic            full;
  logic            wr;
  logic [DW-1:0]   din;
  logic            grant_valid;
  logic [1:0]      grant_id;

  int checks   = 0;
  int failures = 0;

  fifo_rr_write_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_wr     (req_wr),
    .req_din    (req_din),
    .req_ack    (req_ack),
    .full       (full),
    .wr         (wr),
    .din        (din),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic       e_wr;
    logic [3:0] e_ack;
    int         e_src;
    logic       e_gv;
    logic [1:0] e_gid;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] tword(input int i);
    return 32'hC0DE_0000 + DW'(i) * 32'h111;
  endfunction

  // Leaves the bench at a falling edge with rst just released.
  task automatic do_reset();
    rst     = 1'b1;
    req_wr  = '0;
    full    = 1'b0;
    for (int i = 0; i < N; i++) req_din[i*DW +: DW] = tword(i);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] stream [5];
    int            last [N];
    int            maxwait;
    int            nwr;
    logic          exp_wr [7];
    int            seq [N];
    logic          got;
    int            gi;

    // ---------------- reset state ----------------
    do_reset();
    #2;
    check("reset_grant_valid", grant_valid, 0);
    check("reset_grant_id", grant_id, 0);
    check("reset_wr", wr, 0);
    @(negedge clk);

    // ---------------- vector table ----------------
    //            rst  req      full wr  ack     src gv  gid
    vq.push_back('{0, 4'b0000, 0,  0, 4'b0000, 0,  0, 2'd0}); // idle, nothing
    vq.push_back('{0, 4'b0100, 1,  0, 4'b0000, 0,  0, 2'd0}); // full blocks
    vq.push_back('{0, 4'b0100, 0,  1, 4'b0100, 2,  0, 2'd0}); // 2 wins from idle
    vq.push_back('{0, 4'b0100, 0,  1, 4'b0100, 2,  1, 2'd2}); // 2nd write
    vq.push_back('{0, 4'b1000, 0,  0, 4'b0000, 2,  1, 2'd2}); // 2 releases: dead
    vq.push_back('{0, 4'b1001, 0,  1, 4'b1000, 3,  0, 2'd2}); // ptr=3: 3 beats 0
    vq.push_back('{0, 4'b1001, 1,  0, 4'b0000, 3,  1, 2'd3}); // stall, keep grant
    vq.push_back('{0, 4'b1001, 0,  1, 4'b1000, 3,  1, 2'd3});
    vq.push_back('{0, 4'b1001, 0,  1, 4'b1000, 3,  1, 2'd3});
    vq.push_back('{0, 4'b1001, 0,  1, 4'b1000, 3,  1, 2'd3}); // 4th: burst ends
    vq.push_back('{0, 4'b1001, 0,  1, 4'b0001, 0,  0, 2'd3}); // ptr wrapped to 0
    vq.push_back('{1, 4'b0001, 0,  0, 4'b0000, 0,  1, 2'd0}); // reset in BUSY
    vq.push_back('{0, 4'b1000, 0,  1, 4'b1000, 3,  0, 2'd0});
    vq.push_back('{0, 4'b1000, 0,  1, 4'b1000, 3,  1, 2'd3});
    vq.push_back('{1, 4'b1000, 0,  0, 4'b0000, 3,  1, 2'd3}); // reset owner 3
    vq.push_back('{0, 4'b1001, 0,  1, 4'b0001, 0,  0, 2'd0}); // 0 beats 3
    vq.push_back('{0, 4'b0000, 0,  0, 4'b0000, 0,  1, 2'd0}); // release
    vq.push_back('{0, 4'b0001, 0,  1, 4'b0001, 0,  0, 2'd0}); // ptr=1 scan wraps

    foreach (vq[i]) begin
      rst    = vq[i].rst;
      req_wr = vq[i].req;
      full   = vq[i].full;
      #2;
      check($sformatf("vec%0d_wr", i), wr, vq[i].e_wr);
      check($sformatf("vec%0d_ack", i), req_ack, vq[i].e_ack);
      check($sformatf("vec%0d_din", i), din, tword(vq[i].e_src));
      check($sformatf("vec%0d_gv", i), grant_valid, vq[i].e_gv);
      check($sformatf("vec%0d_gid", i), grant_id, vq[i].e_gid);
      @(negedge clk);
    end
    rst = 1'b0;

    // ---------------- single-producer burst, then re-grant ----------------
    do_reset();
    stream = '{32'h5A, 32'hF6, 32'h09, 32'hC4, 32'h81};
    for (int k = 0; k < 5; k++) begin
      req_wr = 4'b0001;
      req_din[0 +: DW] = stream[k];
      #2;
      check($sformatf("burst%0d_wr", k), wr, 1);
      check($sformatf("burst%0d_ack", k), req_ack, 4'b0001);
      check($sformatf("burst%0d_din", k), din, stream[k]);
      check($sformatf("burst%0d_gv", k), grant_valid, (k == 0 || k == 4) ? 1'b0 : 1'b1);
      @(negedge clk);
    end

    // ---------------- all four requesting: rotation ----------------
    do_reset();
    req_wr  = 4'b1111;
    maxwait = 0;
    for (int i = 0; i < N; i++) last[i] = 0;
    for (int c = 0; c < 40; c++) begin
      #2;
      check($sformatf("rot%0d_ack", c), req_ack, 4'b0001 << ((c / MB) % N));
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          if (c - last[i] > maxwait) maxwait = c - last[i];
          last[i] = c;
        end
      end
      @(negedge clk);
    end
    check("rot_max_wait_le_16", maxwait <= 16, 1);

    // ---------------- full stalls producer 1 mid-burst ----------------
    do_reset();
    exp_wr = '{1, 1, 0, 0, 0, 1, 1};
    nwr    = 0;
    req_wr = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      full = (c >= 2 && c <= 4);
      req_din[1*DW +: DW] = 32'h1000 + DW'(nwr);
      #2;
      check($sformatf("stall%0d_wr", c), wr, exp_wr[c]);
      if (c > 0) check($sformatf("stall%0d_gid", c), grant_id, 1);
      if (wr) begin
        check($sformatf("stall%0d_din", c), din, 32'h1000 + DW'(nwr));
        nwr++;
      end
      @(negedge clk);
    end
    req_wr = '0;
    full   = 1'b0;
    #2;
    check("stall_total_writes", nwr, 4);
    check("stall_gv_after", grant_valid, 0);
    check("stall_gid_after", grant_id, 1);
    @(negedge clk);

    // ---------------- random run with per-producer scoreboard ----------------
    do_reset();
    for (int i = 0; i < N; i++) seq[i] = 0;
    got = 1'b0;
    gi  = 0;
    for (int c = 0; c < 10000; c++) begin
      if (got) begin
        seq[gi]++;
        req_wr[gi] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (!req_wr[i]) req_wr[i] = ($urandom_range(0, 3) != 0);
        req_din[i*DW +: DW] = {8'(i), 24'(seq[i])};
      end
      full = ($urandom_range(0, 3) == 0);
      #2;
      check("rand_wr_and_full", wr && full, 0);
      check("rand_ack_onehot0", $onehot0(req_ack), 1);
      check("rand_ack_only_requesters", req_ack & ~req_wr, 0);
      check("rand_wr_is_or_ack", wr, |req_ack);
      got = 1'b0;
      if (wr) begin
        for (int i = 0; i < N; i++) if (req_ack[i]) gi = i;
        got = 1'b1;
        check("rand_din_order", din, {8'(gi), 24'(seq[gi])});
      end
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) check($sformatf("rand_progress%0d", i), seq[i] > 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
